// File: rtl/pll_reset_sequencer.sv
// PLL reset, lock qualification and staged release of the core and video domains.
// Optional retry counter: define PLL_RESET_SEQUENCER_RETRY_CNT_EN.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT       = 100000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGGER_CYCLES     = 8,
    parameter int unsigned CNT_W              = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       rst_core,
    output logic       rst_vid,
    output logic       ready,
    output logic [7:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAIT,
        S_STABLE,
        S_REL_CORE,
        S_RUN
    } state_t;

    localparam logic [CNT_W-1:0] PLL_LOAD     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             locked_m;
    logic             locked_s;
    logic             retry_inc;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_zero ? cnt_q : cnt_q - CNT_ONE;
        retry_inc = 1'b0;
        unique case (state_q)
            S_PLLRST: begin
                if (cnt_zero) begin
                    state_d = S_WAIT;
                    cnt_d   = TIMEOUT_LOAD;
                end
            end
            S_WAIT: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                    cnt_d   = STABLE_LOAD;
                end else if (cnt_zero) begin
                    state_d   = S_PLLRST;
                    cnt_d     = PLL_LOAD;
                    retry_inc = 1'b1;
                end
            end
            S_STABLE: begin
                // a single low sample restarts qualification, not the PLL
                if (!locked_s) begin
                    state_d = S_WAIT;
                    cnt_d   = TIMEOUT_LOAD;
                end else if (cnt_zero) begin
                    state_d = S_REL_CORE;
                    cnt_d   = STAGGER_LOAD;
                end
            end
            S_REL_CORE: begin
                if (!locked_s) begin
                    state_d   = S_PLLRST;
                    cnt_d     = PLL_LOAD;
                    retry_inc = 1'b1;
                end else if (cnt_zero) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d   = S_PLLRST;
                    cnt_d     = PLL_LOAD;
                    retry_inc = 1'b1;
                end
            end
            default: begin
                state_d = S_PLLRST;
                cnt_d   = PLL_LOAD;
            end
        endcase
    end

    // outputs decoded from the next state so they change with the state register
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= S_PLLRST;
            cnt_q    <= PLL_LOAD;
            pll_rst  <= 1'b1;
            rst_core <= 1'b1;
            rst_vid  <= 1'b1;
            ready    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pll_rst  <= (state_d == S_PLLRST);
            rst_core <= !((state_d == S_REL_CORE) || (state_d == S_RUN));
            rst_vid  <= (state_d != S_RUN);
            ready    <= (state_d == S_RUN);
        end
    end

`ifdef PLL_RESET_SEQUENCER_RETRY_CNT_EN
    logic [7:0] retry_q;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            retry_q <= 8'd0;
        end else if (retry_inc && (retry_q != 8'hFF)) begin
            retry_q <= retry_q + 8'd1;
        end
    end

    assign retry_cnt = retry_q;
`else
    logic unused_retry_inc;

    assign unused_retry_inc = retry_inc;
    assign retry_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short bench parameters.
// Expected retry counts follow PLL_RESET_SEQUENCER_RETRY_CNT_EN.
module tb_pll_reset_sequencer;

`ifdef PLL_RESET_SEQUENCER_RETRY_CNT_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst;
    logic       rst_core;
    logic       rst_vid;
    logic       ready;
    logic [7:0] retry_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES    (4),
        .LOCK_TIMEOUT      (50),
        .LOCK_STABLE_CYCLES(10),
        .STAGGER_CYCLES    (3),
        .CNT_W             (17)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .locked   (locked),
        .pll_rst  (pll_rst),
        .rst_core (rst_core),
        .rst_vid  (rst_vid),
        .ready    (ready),
        .retry_cnt(retry_cnt)
    );

    always #5 refclk = ~refclk;

    function automatic int exp_retry(input int n);
        if (!RETRY_EN) return 0;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    // leaves the bench 1ns after an edge with rst just released: cycle 0
    task automatic apply_reset();
        rst    = 1'b1;
        locked = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        logic [3:0] outs;
        rst    = 1'b1;
        locked = 1'b0;
        repeat (2) tick();
        outs = {pll_rst, rst_core, rst_vid, ready};
        n_cmp++;
        if (outs !== 4'b1110) begin
            n_bad++;
            $display("FAIL reset_outs: got %b want 1110", outs);
        end
        n_cmp++;
        if (retry_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_retry: got %0d want 0", retry_cnt);
        end
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (pll_rst !== (cyc < 4)) begin
                n_bad++;
                $display("FAIL reset_pll_rst c%0d: got %b want %b",
                         cyc, pll_rst, (cyc < 4));
            end
            tick();
        end
    endtask

    task automatic test_release();
        int t_core = -1;
        int t_vid  = -1;
        int t_rdy  = -1;
        apply_reset();
        for (int i = 0; i < 45; i++) begin
            if (cyc == 20) locked = 1'b1;
            tick();
            if (t_core < 0 && rst_core === 1'b0) t_core = cyc;
            if (t_vid < 0 && rst_vid === 1'b0) t_vid = cyc;
            if (t_rdy < 0 && ready === 1'b1) t_rdy = cyc;
            n_cmp++;
            if (ready !== (!rst_core && !rst_vid) ||
                (!rst_vid && rst_core)) begin
                n_bad++;
                $display("FAIL rel_invariant c%0d: got c%b v%b r%b",
                         cyc, rst_core, rst_vid, ready);
            end
        end
        n_cmp++;
        if (t_core != 33) begin
            n_bad++;
            $display("FAIL rel_core_time: got %0d want 33", t_core);
        end
        n_cmp++;
        if (t_vid != 36) begin
            n_bad++;
            $display("FAIL rel_vid_time: got %0d want 36", t_vid);
        end
        n_cmp++;
        if (t_rdy != 36) begin
            n_bad++;
            $display("FAIL rel_ready_time: got %0d want 36", t_rdy);
        end
        n_cmp++;
        if (pll_rst !== 1'b0 || retry_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL rel_pll_retry: got %b/%0d want 0/0",
                     pll_rst, retry_cnt);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int k = 1; k <= 300; k++) begin
            while (cyc < 54 * k) tick();
            n_cmp++;
            if (pll_rst !== 1'b1 || rst_core !== 1'b1 ||
                rst_vid !== 1'b1 || ready !== 1'b0) begin
                n_bad++;
                $display("FAIL to_outs k%0d: got %b%b%b%b want 1110",
                         k, pll_rst, rst_core, rst_vid, ready);
            end
            n_cmp++;
            if (int'(retry_cnt) != exp_retry(k)) begin
                n_bad++;
                $display("FAIL to_retry k%0d: got %0d want %0d",
                         k, retry_cnt, exp_retry(k));
            end
            if (k <= 3) begin
                while (cyc < 54 * k + 4) tick();
                n_cmp++;
                if (pll_rst !== 1'b0) begin
                    n_bad++;
                    $display("FAIL to_pll_low k%0d: got %b want 0",
                             k, pll_rst);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int t_core = -1;
        apply_reset();
        for (int i = 0; i < 50; i++) begin
            if (cyc == 20) locked = 1'b1;
            if (cyc == 26) locked = 1'b0;
            if (cyc == 27) locked = 1'b1;
            tick();
            if (t_core < 0 && rst_core === 1'b0) t_core = cyc;
        end
        n_cmp++;
        if (t_core != 40) begin
            n_bad++;
            $display("FAIL glitch_core_time: got %0d want 40", t_core);
        end
        n_cmp++;
        if (retry_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL glitch_retry: got %0d want 0", retry_cnt);
        end
    endtask

    task automatic test_lock_loss();
        int t_core = -1;
        int t_vid  = -1;
        apply_reset();
        while (cyc < 40) begin
            if (cyc == 20) locked = 1'b1;
            tick();
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL loss_pre_ready: got %b want 1", ready);
        end
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        n_cmp++;
        if (ready !== 1'b1 || rst_core !== 1'b0) begin
            n_bad++;
            $display("FAIL loss_c42: got r%b c%b want r1 c0",
                     ready, rst_core);
        end
        tick();
        n_cmp++;
        if ({pll_rst, rst_core, rst_vid, ready} !== 4'b1110) begin
            n_bad++;
            $display("FAIL loss_c43: got %b%b%b%b want 1110",
                     pll_rst, rst_core, rst_vid, ready);
        end
        n_cmp++;
        if (int'(retry_cnt) != exp_retry(1)) begin
            n_bad++;
            $display("FAIL loss_retry: got %0d want %0d",
                     retry_cnt, exp_retry(1));
        end
        while (cyc < 46) tick();
        n_cmp++;
        if (pll_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL loss_pll_c46: got %b want 1", pll_rst);
        end
        tick();
        n_cmp++;
        if (pll_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL loss_pll_c47: got %b want 0", pll_rst);
        end
        while (cyc < 70) begin
            tick();
            if (t_core < 0 && rst_core === 1'b0) t_core = cyc;
            if (t_vid < 0 && rst_vid === 1'b0) t_vid = cyc;
        end
        n_cmp++;
        if (t_core != 58) begin
            n_bad++;
            $display("FAIL loss_rerel_core: got %0d want 58", t_core);
        end
        n_cmp++;
        if (t_vid != 61) begin
            n_bad++;
            $display("FAIL loss_rerel_vid: got %0d want 61", t_vid);
        end
    endtask

    task automatic test_async_reset();
        int t_core = -1;
        apply_reset();
        while (cyc < 34) begin
            if (cyc == 20) locked = 1'b1;
            tick();
        end
        n_cmp++;
        if (rst_core !== 1'b0 || rst_vid !== 1'b1) begin
            n_bad++;
            $display("FAIL async_pre: got c%b v%b want c0 v1",
                     rst_core, rst_vid);
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({pll_rst, rst_core, rst_vid, ready} !== 4'b1110 ||
            retry_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL async_outs: got %b%b%b%b/%0d want 1110/0",
                     pll_rst, rst_core, rst_vid, ready, retry_cnt);
        end
        tick();
        rst = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            if (cyc == 3 || cyc == 4) begin
                n_cmp++;
                if (pll_rst !== (cyc == 3)) begin
                    n_bad++;
                    $display("FAIL async_pll c%0d: got %b want %b",
                             cyc, pll_rst, (cyc == 3));
                end
            end
            tick();
            if (t_core < 0 && rst_core === 1'b0) t_core = cyc;
        end
        n_cmp++;
        if (t_core != 15) begin
            n_bad++;
            $display("FAIL async_rerel_core: got %0d want 15", t_core);
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_timeout();
        test_glitch();
        test_lock_loss();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the video PLL wrapper.
- Runs on the free-running 100 MHz reference clock, drives the PLL's reset input and consumes its locked output.
- Releases the two generated-clock domains in order once lock has been stable for a qualified time:
  - core/PPU domain (43.2 MHz) first;
  - video-out domain (27 MHz) second.
- On lock loss, re-asserts both domain resets and re-runs the PLL reset/lock sequence.

Parameters:
- PLL_RST_CYCLES, 16: refclk cycles pll_rst is held high per attempt (min 1).
- LOCK_TIMEOUT, 100000: refclk cycles to wait for lock before re-resetting the PLL (1 ms).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before release.
- STAGGER_CYCLES, 8: cycles between rst_core release and rst_vid release (min 1).
- CNT_W, 17: width of the shared down-counter; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES, STAGGER_CYCLES).

Ports:
- refclk, input, 1: 100 MHz free-running clock; all logic rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- locked, input, 1: PLL locked, asynchronous to refclk.
- pll_rst, output, 1: reset to PLL, active high.
- rst_core, output, 1: reset request for the 43.2 MHz domain, active high.
- rst_vid, output, 1: reset request for the 27 MHz domain, active high.
- ready, output, 1: high in RUN.
- retry_cnt, output, 8: saturating count of PLL reset attempts after the first (optional feature).

Behaviour:
- Reset values (rst high, asynchronous):
  - state = S_PLLRST, pll_rst = 1, rst_core = 1, rst_vid = 1, ready = 0, retry_cnt = 0;
  - counter loaded with PLL_RST_CYCLES-1, lock synchronizer cleared.
- All outputs are registered, with no combinational paths from inputs to outputs.
- Downstream domains synchronize deassertion locally; this block only guarantees assertion is glitch-free.
- locked passes through a 2-FF synchronizer to locked_s, giving 2 cycles of latency.
- S_PLLRST:
  - pll_rst = 1 for exactly PLL_RST_CYCLES cycles;
  - then go to S_WAIT with counter = LOCK_TIMEOUT-1.
- S_WAIT:
  - pll_rst = 0;
  - if locked_s = 1, go to S_STABLE with counter = LOCK_STABLE_CYCLES-1;
  - else if counter = 0, go to S_PLLRST (timeout; retry_cnt++ saturating at 255);
  - else decrement.
- S_STABLE:
  - if locked_s = 0, go to S_WAIT with the timeout counter reloaded (glitch restarts qualification; no retry increment);
  - if counter = 0 and locked_s = 1, go to S_REL_CORE;
  - so release follows exactly LOCK_STABLE_CYCLES consecutive high samples.
- S_REL_CORE:
  - rst_core deasserts on entry;
  - hold for STAGGER_CYCLES cycles, then go to S_RUN.
- S_RUN:
  - entry deasserts rst_vid and asserts ready in the same cycle.
- Lock loss in S_REL_CORE or S_RUN (locked_s = 0):
  - next cycle rst_core = 1, rst_vid = 1, ready = 0;
  - state goes to S_PLLRST; retry_cnt++.
- Precedence (same cycle): lock loss beats counter expiry. In S_WAIT, locked_s = 1 beats timeout.
- The counter never underflows; it is reloaded on every state entry.
- Invariant: rst_vid = 0 implies rst_core = 0. ready = 1 if and only if both resets are low.
- rst asserted mid-sequence returns the block to the reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro PLL_RESET_SEQUENCER_RETRY_CNT_EN.
- Defined: the retry_cnt register exists as described above (8-bit, saturating, cleared only by rst).
- Undefined: the register is removed and retry_cnt is tied to 8'd0. All other behaviour is identical.

Test Plan:
Bench parameters are PLL_RST_CYCLES=4, LOCK_TIMEOUT=50, LOCK_STABLE_CYCLES=10, STAGGER_CYCLES=3.
- Release rst, locked high from cycle 20: pll_rst high cycles 0-3 then 0; rst_core falls at cycle 20+2+10+1 (±1 for the synchronizer edge); rst_vid falls and ready rises exactly 3 cycles later; retry_cnt = 0.
- locked held low: pll_rst re-pulses for 4 cycles every 54 cycles; retry_cnt = 1, 2, 3…; rst_core and rst_vid stay 1. Force 300 attempts: retry_cnt saturates at 255.
- locked high for 6 cycles, low for 1 cycle, then high: no release until 10 new consecutive high samples; retry_cnt unchanged.
- In S_RUN, drop locked for 1 cycle: 3 cycles later rst_core = rst_vid = 1 and ready = 0; pll_rst pulses 4 cycles; retry_cnt increments by 1; full re-release follows.
- Assert rst asynchronously mid S_REL_CORE: all outputs return to reset values before the next refclk edge. Sequence restarts from S_PLLRST.
- Build without the macro and rerun the timeout test: retry_cnt = 0 throughout; all timings match the defined build.
